// File: rtl/y_pool_quant.sv
// y_pool_quant: max-pool, ReLU, shift and saturate the conv core y stream.
// Results leave through a 2-entry buffered valid/ready stream with frame-last.
module y_pool_quant #(
  parameter int IN_W  = 21,
  parameter int OUT_W = 8,
  parameter int FRAME = 97,
  parameter int POOL  = 4,
  parameter int SHIFT = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [IN_W-1:0] s_data_in_y,
  input  logic                   s_valid_y,
  output logic                   s_ready_y,
  output logic [OUT_W-1:0]       m_data_out_z,
  output logic                   m_valid_z,
  input  logic                   m_ready_z,
  output logic                   m_last_z
);

  localparam int PW = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int FW = (FRAME > 1) ? $clog2(FRAME) : 1;

  localparam logic [PW-1:0] POS_LAST = PW'(POOL - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(FRAME - 1);

  localparam logic signed [IN_W-1:0] SAT_V =
    IN_W'((2 ** (OUT_W - 1)) - 1);

  logic [PW-1:0]          pos_q, pos_d;
  logic [FW-1:0]          frm_q, frm_d;
  logic signed [IN_W-1:0] max_q, max_d;

  logic [OUT_W-1:0] dat0_q, dat0_d;
  logic [OUT_W-1:0] dat1_q, dat1_d;
  logic             lst0_q, lst0_d;
  logic             lst1_q, lst1_d;
  logic [1:0]       cnt_q, cnt_d;

  logic                   acc;
  logic                   pop;
  logic                   push;
  logic                   frm_end;
  logic signed [IN_W-1:0] win_max;
  logic signed [IN_W-1:0] shifted;
  logic [OUT_W-1:0]       res;

  // Ready and output view depend on registered state only
  always_comb begin
    s_ready_y    = !reset && (cnt_q != 2'd2);
    m_valid_z    = (cnt_q != 2'd0);
    m_data_out_z = m_valid_z ? dat0_q : '0;
    m_last_z     = m_valid_z ? lst0_q : 1'b0;
  end

  // Window tracking, running max and the quantized result of the window
  always_comb begin
    acc     = s_valid_y && s_ready_y;
    pop     = m_valid_z && m_ready_z;
    frm_end = (frm_q == FRM_LAST);
    push    = acc && ((pos_q == POS_LAST) || frm_end);

    if ((pos_q == '0) || (s_data_in_y > max_q))
      win_max = s_data_in_y;
    else
      win_max = max_q;

    shifted = win_max >>> SHIFT;
    if (win_max[IN_W-1])
      res = '0;
    else if (shifted > SAT_V)
      res = SAT_V[OUT_W-1:0];
    else
      res = shifted[OUT_W-1:0];

    pos_d = pos_q;
    frm_d = frm_q;
    max_d = max_q;
    if (acc) begin
      max_d = win_max;
      pos_d = push ? '0 : pos_q + PW'(1);
      frm_d = frm_end ? '0 : frm_q + FW'(1);
    end
  end

  // Two-entry FIFO: entry 0 is the head, order kept on push+pop
  always_comb begin
    cnt_d  = cnt_q;
    dat0_d = dat0_q;
    dat1_d = dat1_q;
    lst0_d = lst0_q;
    lst1_d = lst1_q;
    if (push && pop) begin
      if (cnt_q == 2'd1) begin
        dat0_d = res;
        lst0_d = frm_end;
      end else begin
        dat0_d = dat1_q;
        lst0_d = lst1_q;
        dat1_d = res;
        lst1_d = frm_end;
      end
    end else if (push) begin
      if (cnt_q == 2'd0) begin
        dat0_d = res;
        lst0_d = frm_end;
      end else begin
        dat1_d = res;
        lst1_d = frm_end;
      end
      cnt_d = cnt_q + 2'd1;
    end else if (pop) begin
      dat0_d = dat1_q;
      lst0_d = lst1_q;
      cnt_d  = cnt_q - 2'd1;
    end
  end

  // State registers, cleared immediately by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q  <= '0;
      frm_q  <= '0;
      max_q  <= '0;
      dat0_q <= '0;
      dat1_q <= '0;
      lst0_q <= 1'b0;
      lst1_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      pos_q  <= pos_d;
      frm_q  <= frm_d;
      max_q  <= max_d;
      dat0_q <= dat0_d;
      dat1_q <= dat1_d;
      lst0_q <= lst0_d;
      lst1_q <= lst1_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_y_pool_quant.sv
// tb_y_pool_quant: scenario tasks against a window-list reference model.
// Inputs change at negedge, outputs are sampled 1ns later.
module tb_y_pool_quant;

  localparam int IN_W  = 21;
  localparam int OUT_W = 8;
  localparam int FRAME = 97;
  localparam int POOL  = 4;
  localparam int SHIFT = 6;
  localparam int RPF   = 25;
  localparam int NF    = 300;

  logic                   clk = 1'b0;
  logic                   reset;
  logic signed [IN_W-1:0] s_data_in_y;
  logic                   s_valid_y;
  logic                   s_ready_y;
  logic [OUT_W-1:0]       m_data_out_z;
  logic                   m_valid_z;
  logic                   m_ready_z;
  logic                   m_last_z;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  y_pool_quant dut (
    .clk          (clk),
    .reset        (reset),
    .s_data_in_y  (s_data_in_y),
    .s_valid_y    (s_valid_y),
    .s_ready_y    (s_ready_y),
    .m_data_out_z (m_data_out_z),
    .m_valid_z    (m_valid_z),
    .m_ready_z    (m_ready_z),
    .m_last_z     (m_last_z)
  );

  typedef struct {
    int d;
    bit l;
  } exp_t;

  int   m_idx;
  int   m_win[$];
  exp_t exp_q[$];

  function automatic int quant(int w);
    int r;
    if (w < 0) return 0;
    r = w / (1 << SHIFT);
    if (r > (1 << (OUT_W - 1)) - 1) r = (1 << (OUT_W - 1)) - 1;
    return r;
  endfunction

  function automatic void model_reset();
    m_idx = 0;
    m_win.delete();
    exp_q.delete();
  endfunction

  function automatic void model_accept(int v);
    int   mx;
    exp_t e;
    m_win.push_back(v);
    if (m_win.size() == POOL || m_idx == FRAME - 1) begin
      mx = m_win[0];
      foreach (m_win[i]) if (m_win[i] > mx) mx = m_win[i];
      e.d = quant(mx);
      e.l = (m_idx == FRAME - 1);
      exp_q.push_back(e);
      m_win.delete();
    end
    m_idx = (m_idx == FRAME - 1) ? 0 : m_idx + 1;
  endfunction

  function automatic int rnd_val();
    logic signed [IN_W-1:0] t;
    t = IN_W'($urandom);
    if ($urandom_range(0, 1) == 0)
      t = IN_W'($signed($urandom_range(0, 20000)) - 6000);
    return int'(t);
  endfunction

  task automatic step(input bit v, input int d, input bit r,
                      output bit acc, output bit popd,
                      output logic [OUT_W-1:0] od, output logic ol);
    @(negedge clk);
    s_valid_y   = v;
    s_data_in_y = v ? IN_W'(d) : 'x;
    m_ready_z   = r;
    #1;
    acc  = s_valid_y && s_ready_y;
    popd = m_valid_z && m_ready_z;
    od   = m_data_out_z;
    ol   = m_last_z;
    if (acc) model_accept(d);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    s_valid_y = 1'b0;
    m_ready_z = 1'b0;
    s_data_in_y = 'x;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (s_ready_y !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_ready got=%b exp=0", s_ready_y);
    end
    n_cmp++;
    if (m_valid_z !== 1'b0 || m_data_out_z !== '0 || m_last_z !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_out got v=%b d=%0d l=%b exp 0/0/0",
               m_valid_z, m_data_out_z, m_last_z);
    end
    reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (s_ready_y !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_release_ready got=%b exp=1", s_ready_y);
    end
  endtask

  task automatic test_ramp();
    bit               acc, popd;
    logic [OUT_W-1:0] od;
    logic             ol;
    exp_t             e;
    int               k;
    int               cd;
    k = 0;
    for (int i = 0; i < FRAME + 6; i++) begin
      step(i < FRAME, 64 * i, 1'b1, acc, popd, od, ol);
      if (popd) begin
        cd = (k < RPF - 1) ? 4 * k + 3 : 96;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL ramp_extra got=%0d", od);
        end else begin
          e = exp_q.pop_front();
          if (od !== OUT_W'(e.d) || ol !== e.l || od !== OUT_W'(cd)
              || ol !== (k == RPF - 1)) begin
            n_bad++;
            $display("FAIL ramp_out k=%0d got=%0d/%b exp=%0d/%b",
                     k, od, ol, cd, (k == RPF - 1));
          end
        end
        k++;
      end
    end
    n_cmp++;
    if (k != RPF) begin
      n_bad++;
      $display("FAIL ramp_count got=%0d exp=%0d", k, RPF);
    end
  endtask

  task automatic test_negative_sat();
    bit               acc, popd;
    logic [OUT_W-1:0] od;
    logic             ol;
    exp_t             e;
    int               k;
    int               v;
    int               sat_exp[4];
    sat_exp = '{0, 127, 127, 126};
    k = 0;
    for (int i = 0; i < 2 * FRAME + 6; i++) begin
      v = -1000;
      if (i >= FRAME) begin
        case (i - FRAME)
          0: v = -5;
          1: v = -2;
          2: v = -900;
          3: v = -1;
          4: v = 1048575;
          8: v = 8191;
          12: v = 8127;
          5, 6, 7, 9, 10, 11, 13, 14, 15: v = 0;
          default: v = -1;
        endcase
      end
      step(i < 2 * FRAME, v, 1'b1, acc, popd, od, ol);
      if (popd) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL neg_extra got=%0d", od);
        end else begin
          e = exp_q.pop_front();
          if (k >= RPF && k < RPF + 4) e.d = sat_exp[k - RPF];
          else if (k < RPF) e.d = 0;
          if (od !== OUT_W'(e.d) || ol !== e.l) begin
            n_bad++;
            $display("FAIL neg_sat_out k=%0d got=%0d/%b exp=%0d/%b",
                     k, od, ol, e.d, e.l);
          end
        end
        k++;
      end
    end
    n_cmp++;
    if (k != 2 * RPF) begin
      n_bad++;
      $display("FAIL neg_count got=%0d exp=%0d", k, 2 * RPF);
    end
  endtask

  task automatic test_backpressure();
    bit               acc, popd;
    logic [OUT_W-1:0] od;
    logic             ol;
    exp_t             e;
    int               n_acc;
    int               k;
    int               sent;
    n_acc = 0;
    sent  = 0;
    for (int c = 0; c < 30; c++) begin
      step(1'b1, 300 * sent + 17, 1'b0, acc, popd, od, ol);
      if (acc) begin
        n_acc++;
        sent++;
      end
      if (m_valid_z && exp_q.size() > 0) begin
        n_cmp++;
        if (od !== OUT_W'(exp_q[0].d)) begin
          n_bad++;
          $display("FAIL bp_head c=%0d got=%0d exp=%0d", c, od, exp_q[0].d);
        end
      end
    end
    n_cmp++;
    if (n_acc != 8) begin
      n_bad++;
      $display("FAIL bp_accepts got=%0d exp=8", n_acc);
    end
    n_cmp++;
    if (s_ready_y !== 1'b0 || m_valid_z !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_stall got rdy=%b vld=%b exp 0/1",
               s_ready_y, m_valid_z);
    end
    k = 0;
    for (int c = 0; c < 300 && (sent < FRAME || exp_q.size() > 0); c++) begin
      step(sent < FRAME, 300 * sent + 17, 1'b1, acc, popd, od, ol);
      if (acc) sent++;
      if (popd) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL bp_extra got=%0d", od);
        end else begin
          e = exp_q.pop_front();
          if (od !== OUT_W'(e.d) || ol !== e.l) begin
            n_bad++;
            $display("FAIL bp_out k=%0d got=%0d/%b exp=%0d/%b",
                     k, od, ol, e.d, e.l);
          end
        end
        k++;
      end
    end
    n_cmp++;
    if (k != RPF || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_count got=%0d exp=%0d", k, RPF);
    end
  endtask

  task automatic test_async_reset();
    bit               acc, popd;
    logic [OUT_W-1:0] od;
    logic             ol;
    exp_t             e;
    int               sent;
    int               k;
    sent = 0;
    while (sent < 50) begin
      step(1'b1, rnd_val(), 1'b0, acc, popd, od, ol);
      if (acc) sent++;
      if (!s_ready_y) begin
        step(1'b0, 0, 1'b1, acc, popd, od, ol);
        if (popd) exp_q.pop_front();
      end
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (m_valid_z !== 1'b0 || m_data_out_z !== '0 || m_last_z !== 1'b0
        || s_ready_y !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_out got v=%b d=%0d l=%b r=%b exp 0/0/0/0",
               m_valid_z, m_data_out_z, m_last_z, s_ready_y);
    end
    s_valid_y = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    sent = 0;
    k    = 0;
    for (int c = 0; c < 300 && (sent < FRAME || exp_q.size() > 0); c++) begin
      step(sent < FRAME, rnd_val(), 1'b1, acc, popd, od, ol);
      if (acc) sent++;
      if (popd) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL arst_extra got=%0d", od);
        end else begin
          e = exp_q.pop_front();
          if (od !== OUT_W'(e.d) || ol !== e.l) begin
            n_bad++;
            $display("FAIL arst_out k=%0d got=%0d/%b exp=%0d/%b",
                     k, od, ol, e.d, e.l);
          end
        end
        k++;
      end
    end
    n_cmp++;
    if (k != RPF) begin
      n_bad++;
      $display("FAIL arst_count got=%0d exp=%0d", k, RPF);
    end
  endtask

  task automatic test_random();
    bit               acc, popd;
    logic [OUT_W-1:0] od;
    logic             ol;
    exp_t             e;
    int               sent;
    int               k;
    bit               v;
    sent = 0;
    k    = 0;
    for (int c = 0; c < 80000 && (sent < NF * FRAME || exp_q.size() > 0);
         c++) begin
      v = (sent < NF * FRAME) && ($urandom_range(0, 3) != 0);
      step(v, rnd_val(), $urandom_range(0, 9) < 7, acc, popd, od, ol);
      if (acc) sent++;
      if (popd) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rand_extra got=%0d", od);
        end else begin
          e = exp_q.pop_front();
          if (od !== OUT_W'(e.d) || ol !== e.l
              || ol !== ((k % RPF) == RPF - 1)) begin
            n_bad++;
            $display("FAIL rand_out k=%0d got=%0d/%b exp=%0d/%b",
                     k, od, ol, e.d, e.l);
          end
        end
        k++;
      end
    end
    n_cmp++;
    if (k != NF * RPF) begin
      n_bad++;
      $display("FAIL rand_count got=%0d exp=%0d", k, NF * RPF);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp();
    test_negative_sat();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
